// File: rtl/spram_lsu.sv
// Load/store initiator for the single-port data RAM: one RV32 access at a time,
// sub-word loads extracted from a word read, unaligned sub-word stores done as read-modify-write.
module spram_lsu #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_rden,
    output logic                  mem_wren,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [2:0]            mem_rwtyp,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam int AW = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {IDLE, RD, LDATA, MERGE, WR} state_t;

    state_t          state;
    state_t          state_next;
    logic            we_r;
    logic [AW-1:0]   addr_r;
    logic [2:0]      funct3_r;
    logic [31:0]     wdata_r;
    logic [31:0]     merged_r;
    logic            accept;
    logic            req_error;
    logic            req_direct;
    logic            wr_direct;
    logic [31:0]     lane_shifted;
    logic [31:0]     load_val;
    logic [31:0]     merge_val;

    assign accept      = req_valid && (state == IDLE);
    assign mem_address = addr_r[AW-1:2];

    // A word store, or a sub-word store landing on byte 0, fits the RAM's low-lane write directly.
    assign req_direct = (req_funct3[1:0] == 2'b10) || (req_addr[1:0] == 2'b00);
    assign wr_direct  = (funct3_r[1:0] == 2'b10) || (addr_r[1:0] == 2'b00);

    always_comb begin
        req_error = 1'b0;
        if (req_we) begin
            if (req_funct3[2] || (req_funct3[1:0] == 2'b11))
                req_error = 1'b1;
        end else begin
            if ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11))
                req_error = 1'b1;
        end
        if ((req_funct3[1:0] == 2'b01) && req_addr[0])
            req_error = 1'b1;
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
            req_error = 1'b1;
        if ((req_addr >> AW) != 32'd0)
            req_error = 1'b1;
    end

    always_comb begin
        lane_shifted = mem_q >> {addr_r[1:0], 3'b000};
        case (funct3_r[1:0])
            2'b00:   load_val = funct3_r[2] ? {24'd0, lane_shifted[7:0]}
                                            : {{24{lane_shifted[7]}}, lane_shifted[7:0]};
            2'b01:   load_val = funct3_r[2] ? {16'd0, lane_shifted[15:0]}
                                            : {{16{lane_shifted[15]}}, lane_shifted[15:0]};
            default: load_val = mem_q;
        endcase
    end

    always_comb begin
        merge_val = mem_q;
        if (funct3_r[0])
            merge_val[{addr_r[1], 4'b0000} +: 16] = wdata_r[15:0];
        else
            merge_val[{addr_r[1:0], 3'b000} +: 8] = wdata_r[7:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        mem_rden   = 1'b0;
        mem_wren   = 1'b0;
        mem_data   = '0;
        mem_rwtyp  = 3'b000;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (accept && !req_error) begin
                    if (req_we && req_direct)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD: begin
                mem_rden   = 1'b1;
                mem_rwtyp  = 3'b010;
                state_next = we_r ? MERGE : LDATA;
            end
            LDATA:   state_next = IDLE;
            MERGE:   state_next = WR;
            WR: begin
                mem_wren   = 1'b1;
                state_next = IDLE;
                if (wr_direct) begin
                    mem_data  = wdata_r;
                    mem_rwtyp = {1'b0, funct3_r[1:0]};
                end else begin
                    mem_data  = merged_r;
                    mem_rwtyp = 3'b010;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request registers, merged word and the registered response; rsp_rdata/rsp_err hold between pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_r      <= 1'b0;
            addr_r    <= '0;
            funct3_r  <= 3'b000;
            wdata_r   <= 32'd0;
            merged_r  <= 32'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                we_r     <= req_we;
                addr_r   <= req_addr[AW-1:0];
                funct3_r <= req_funct3;
                wdata_r  <= req_wdata;
                if (req_error) begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b1;
                    rsp_rdata <= 32'd0;
                end
            end
            if (state == LDATA) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= load_val;
            end
            if (state == MERGE)
                merged_r <= merge_val;
            if (state == WR) begin
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_spram_lsu.sv
// Directed bench for spram_lsu: a behavioural low-lane RAM, a vector table of single
// requests, and hand-written back-to-back and reset-mid-RMW sequences.
module tb_spram_lsu;

    logic        clk;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] mem_address;
    logic        mem_rden;
    logic        mem_wren;
    logic [31:0] mem_data;
    logic [2:0]  mem_rwtyp;
    logic [31:0] mem_q;

    int tests_run    = 0;
    int tests_failed = 0;

    int          wr_cnt  = 0;
    int          rd_cnt  = 0;
    int          rsp_cnt = 0;
    int          overlap = 0;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic [2:0]  wr_typ;
    logic [15:0] rd_addr;

    logic [31:0] ram [0:65535];

    typedef struct {
        bit          we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] e_rdata;
        bit          e_err;
        int          e_lat;
        int          e_wr;
        int          e_rd;
        logic [31:0] e_mdata;
        logic [2:0]  e_rwtyp;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [0:NVEC-1];

    spram_lsu #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_address(mem_address),
        .mem_rden   (mem_rden),
        .mem_wren   (mem_wren),
        .mem_data   (mem_data),
        .mem_rwtyp  (mem_rwtyp),
        .mem_q      (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM with low-lane sub-word writes and a registered read port.
    always @(posedge clk) begin
        if (mem_wren) begin
            case (mem_rwtyp)
                3'b000:  ram[mem_address][7:0]  <= mem_data[7:0];
                3'b001:  ram[mem_address][15:0] <= mem_data[15:0];
                default: ram[mem_address]       <= mem_data;
            endcase
        end
        if (mem_rden)
            mem_q <= ram[mem_address];
    end

    always @(negedge clk) begin
        if (mem_wren) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = mem_address;
            wr_data = mem_data;
            wr_typ  = mem_rwtyp;
        end
        if (mem_rden) begin
            rd_cnt  = rd_cnt + 1;
            rd_addr = mem_address;
        end
        if (mem_rden && mem_wren)
            overlap = overlap + 1;
        if (rsp_valid)
            rsp_cnt = rsp_cnt + 1;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (act !== exp) begin
            tests_failed = tests_failed + 1;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"},   {31'd0, req_ready}, 32'd1);
        checkOutput({tag, "_rspv"},    {31'd0, rsp_valid}, 32'd0);
        checkOutput({tag, "_err"},     {31'd0, rsp_err},   32'd0);
        checkOutput({tag, "_rdata"},   rsp_rdata,          32'd0);
        checkOutput({tag, "_rden"},    {31'd0, mem_rden},  32'd0);
        checkOutput({tag, "_wren"},    {31'd0, mem_wren},  32'd0);
        checkOutput({tag, "_address"}, {16'd0, mem_address}, 32'd0);
        checkOutput({tag, "_mdata"},   mem_data,           32'd0);
        checkOutput({tag, "_rwtyp"},   {29'd0, mem_rwtyp}, 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int wr0;
        int rd0;
        int lat;
        bit ready_bad;
        @(negedge clk);
        checkOutput({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
        wr0        = wr_cnt;
        rd0        = rd_cnt;
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = ~v.we;
        req_funct3 = 3'b111;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'hA5A5_A5A5;
        lat        = -1;
        ready_bad  = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                break;
            end
            if (req_ready)
                ready_bad = 1'b1;
        end
        checkOutput({tag, "_latency"}, lat, v.e_lat);
        checkOutput({tag, "_rdata"}, rsp_rdata, v.e_rdata);
        checkOutput({tag, "_err"}, {31'd0, rsp_err}, {31'd0, v.e_err});
        checkOutput({tag, "_ready_at_rsp"}, {31'd0, req_ready}, 32'd1);
        checkOutput({tag, "_ready_busy"}, {31'd0, ready_bad}, 32'd0);
        checkOutput({tag, "_wr_pulses"}, wr_cnt - wr0, v.e_wr);
        checkOutput({tag, "_rd_pulses"}, rd_cnt - rd0, v.e_rd);
        if (v.e_wr > 0) begin
            checkOutput({tag, "_wr_addr"}, {16'd0, wr_addr}, (v.addr >> 2) & 32'h0000_FFFF);
            checkOutput({tag, "_wr_data"}, wr_data, v.e_mdata);
            checkOutput({tag, "_wr_rwtyp"}, {29'd0, wr_typ}, {29'd0, v.e_rwtyp});
        end
        if (v.e_rd > 0)
            checkOutput({tag, "_rd_addr"}, {16'd0, rd_addr}, (v.addr >> 2) & 32'h0000_FFFF);
        @(negedge clk);
        checkOutput({tag, "_pulse_end"}, {31'd0, rsp_valid}, 32'd0);
        checkOutput({tag, "_rdata_held"}, rsp_rdata, v.e_rdata);
    endtask

    initial begin
        int   wr0;
        int   rsp0;
        int   lat;
        vec_t v;

        // we, f3, addr, wdata, rdata, err, lat, wr, rd, mem_data, rwtyp
        vecs[0]  = '{1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 1, 0, 32'hDEADBEEF, 3'b010};
        vecs[1]  = '{0, 3'b010, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0, 1, 32'h0,        3'b000};
        vecs[2]  = '{1, 3'b010, 32'h20, 32'h80FF7F01, 32'h0,        0, 1, 1, 0, 32'h80FF7F01, 3'b010};
        vecs[3]  = '{0, 3'b000, 32'h21, 32'h0,        32'h0000007F, 0, 2, 0, 1, 32'h0,        3'b000};
        vecs[4]  = '{0, 3'b000, 32'h23, 32'h0,        32'hFFFFFF80, 0, 2, 0, 1, 32'h0,        3'b000};
        vecs[5]  = '{0, 3'b100, 32'h23, 32'h0,        32'h00000080, 0, 2, 0, 1, 32'h0,        3'b000};
        vecs[6]  = '{0, 3'b001, 32'h22, 32'h0,        32'hFFFF80FF, 0, 2, 0, 1, 32'h0,        3'b000};
        vecs[7]  = '{0, 3'b101, 32'h22, 32'h0,        32'h000080FF, 0, 2, 0, 1, 32'h0,        3'b000};
        vecs[8]  = '{1, 3'b010, 32'h30, 32'h11223344, 32'h0,        0, 1, 1, 0, 32'h11223344, 3'b010};
        vecs[9]  = '{1, 3'b000, 32'h31, 32'h000000AA, 32'h0,        0, 3, 1, 1, 32'h1122AA44, 3'b010};
        vecs[10] = '{1, 3'b001, 32'h32, 32'h0000BEEF, 32'h0,        0, 3, 1, 1, 32'hBEEFAA44, 3'b010};
        vecs[11] = '{1, 3'b000, 32'h30, 32'h00000055, 32'h0,        0, 1, 1, 0, 32'h00000055, 3'b000};
        vecs[12] = '{0, 3'b010, 32'h30, 32'h0,        32'hBEEFAA55, 0, 2, 0, 1, 32'h0,        3'b000};
        vecs[13] = '{0, 3'b001, 32'h41, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        3'b000};
        vecs[14] = '{1, 3'b010, 32'h42, 32'h12345678, 32'h0,        1, 0, 0, 0, 32'h0,        3'b000};
        vecs[15] = '{0, 3'b011, 32'h40, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        3'b000};
        vecs[16] = '{0, 3'b010, 32'h00040000, 32'h0,  32'h0,        1, 0, 0, 0, 32'h0,        3'b000};
        vecs[17] = '{1, 3'b000, 32'h33, 32'h12345677, 32'h0,        0, 3, 1, 1, 32'h77EFAA55, 3'b010};
        vecs[18] = '{0, 3'b100, 32'h33, 32'h0,        32'h00000077, 0, 2, 0, 1, 32'h0,        3'b000};
        vecs[19] = '{0, 3'b000, 32'h31, 32'h0,        32'hFFFFFFAA, 0, 2, 0, 1, 32'h0,        3'b000};
        vecs[20] = '{1, 3'b001, 32'h30, 32'hFFFF1234, 32'h0,        0, 1, 1, 0, 32'hFFFF1234, 3'b001};
        vecs[21] = '{0, 3'b010, 32'h30, 32'h0,        32'h77EF1234, 0, 2, 0, 1, 32'h0,        3'b000};
        vecs[22] = '{1, 3'b011, 32'h30, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        3'b000};
        vecs[23] = '{1, 3'b100, 32'h30, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        3'b000};
        vecs[24] = '{0, 3'b110, 32'h30, 32'h0,        32'h0,        1, 0, 0, 0, 32'h0,        3'b000};

        rstn       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_funct3 = 3'b000;
        req_wdata  = 32'd0;
        #2;
        checkResetValues("reset");
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkResetValues("post_reset");

        for (int i = 0; i < NVEC; i++)
            applyStimulus(vecs[i], $sformatf("v%0d", i));

        // Held req_valid: the store is presented during the load and taken in its rsp_valid cycle.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_wdata  = 32'd0;
        @(posedge clk);
        #1;
        req_we     = 1'b1;
        req_addr   = 32'h50;
        req_wdata  = 32'hCAFEF00D;
        lat        = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        checkOutput("b2b_load_latency", lat, 32'd2);
        checkOutput("b2b_load_rdata", rsp_rdata, 32'hDEADBEEF);
        checkOutput("b2b_ready_at_rsp", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("b2b_ready_wr", {31'd0, req_ready}, 32'd0);
        checkOutput("b2b_rspv_wr", {31'd0, rsp_valid}, 32'd0);
        checkOutput("b2b_wren", {31'd0, mem_wren}, 32'd1);
        checkOutput("b2b_wr_addr", {16'd0, mem_address}, 32'h14);
        checkOutput("b2b_wr_data", mem_data, 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("b2b_store_rspv", {31'd0, rsp_valid}, 32'd1);
        checkOutput("b2b_store_err", {31'd0, rsp_err}, 32'd0);
        v = '{0, 3'b010, 32'h50, 32'h0, 32'hCAFEF00D, 0, 2, 0, 1, 32'h0, 3'b000};
        applyStimulus(v, "b2b_readback");

        // Reset during MERGE of an SB at byte 1: no write, no response, RAM word intact.
        v = '{1, 3'b010, 32'h30, 32'h11223344, 32'h0, 0, 1, 1, 0, 32'h11223344, 3'b010};
        applyStimulus(v, "rst_pre_sw");
        v = '{0, 3'b010, 32'h30, 32'h0, 32'h11223344, 0, 2, 0, 1, 32'h0, 3'b000};
        applyStimulus(v, "rst_pre_lw");
        @(negedge clk);
        wr0        = wr_cnt;
        rsp0       = rsp_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h31;
        req_wdata  = 32'h000000AA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_rd_phase", {31'd0, mem_rden}, 32'd1);
        @(negedge clk);
        checkOutput("rst_merge_rden", {31'd0, mem_rden}, 32'd0);
        checkOutput("rst_merge_wren", {31'd0, mem_wren}, 32'd0);
        rstn = 1'b0;
        #1;
        checkResetValues("rst_mid");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checkOutput("rst_no_write", wr_cnt - wr0, 32'd0);
        checkOutput("rst_no_rsp", rsp_cnt - rsp0, 32'd0);
        v = '{0, 3'b010, 32'h30, 32'h0, 32'h11223344, 0, 2, 0, 1, 32'h0, 3'b000};
        applyStimulus(v, "rst_readback");

        checkOutput("rden_wren_overlap", overlap, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spram_lsu.md
# spram_lsu

Load/store initiator that drives the single-port data RAM's `address/rden/wren/data/rwtyp/q` port on behalf of the CPU memory stage. It accepts one RV32 byte-addressed load or store at a time, maps it onto the RAM's word-addressed, low-lane-only sub-word interface, and returns one response per request. Sub-word loads are extracted from a full-word read and then sign- or zero-extended. Sub-word stores at a non-zero byte offset are performed as read-modify-write.

## Interface
- `ADDR_WIDTH`, 16: RAM word-address width. Must be ≤ 30.
- `DATA_WIDTH`, 32: RAM data width. Fixed at 32.
- `clk` input 1: clock.
- `rstn` input 1: reset; asynchronous, active-low.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request; high only in IDLE.
- `req_we` input 1: 1 = store, 0 = load.
- `req_addr` input 32: byte address.
- `req_funct3` input 3: RV32 funct3. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW.
- `req_wdata` input 32: store data, right-aligned.
- `rsp_valid` output 1: one-cycle response pulse.
- `rsp_rdata` output 32: load result; 0 for stores and errors.
- `rsp_err` output 1: request rejected; valid with `rsp_valid`.
- `mem_address` output ADDR_WIDTH: RAM word address, equal to `req_addr[ADDR_WIDTH+1:2]`.
- `mem_rden` output 1: RAM read enable.
- `mem_wren` output 1: RAM write enable.
- `mem_data` output 32: RAM write data.
- `mem_rwtyp` output 3: RAM access type. 000 low byte, 001 low half, 010 word.
- `mem_q` input 32: RAM read data, valid the cycle after `mem_rden`.

## Operation
- **Request capture.** A request is accepted on a clock edge where `req_valid && req_ready` is true. On acceptance the block registers `we`, `addr`, `funct3` and `wdata`. All `mem_*` outputs are driven from these registers and the current state.
- **Error checks.** A request is flagged as an error, with no RAM access, when any of the following holds:
  - `funct3` is invalid: 011/110/111 for a load, or any value other than 000/001/010 for a store.
  - The access is misaligned: halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - `addr[31:ADDR_WIDTH+2]` is non-zero.
- **States:** IDLE, RD, LDATA, MERGE, WR.
- **Transitions:**
  - IDLE → RD on an accepted load.
  - IDLE → WR on an accepted SW, or an SB/SH whose target starts at byte 0 (`addr[1:0]`=00).
  - IDLE → RD on any other accepted SB/SH (read-modify-write).
  - IDLE → IDLE on an error; the response is issued directly.
  - RD → LDATA for a load; RD → MERGE for a store.
  - LDATA → IDLE, registering the response.
  - MERGE → WR, registering the merged word.
  - WR → IDLE, registering the response.
- **RD:** `mem_rden`=1, `mem_rwtyp`=010.
- **LDATA:** extract from `mem_q`, then extend.
  - Byte: `mem_q[8*addr[1:0] +: 8]`.
  - Halfword: `mem_q[16*addr[1] +: 16]`.
  - Sign-extend when `funct3[2]`=0; zero-extend when `funct3[2]`=1.
- **MERGE:** take `mem_q` and replace the target lane with `wdata[7:0]` (byte) or `wdata[15:0]` (half).
- **WR:** `mem_wren`=1.
  - Direct write: `mem_data`=`wdata`, `mem_rwtyp`=`{1'b0, funct3[1:0]}`.
  - RMW write: `mem_data`=merged word, `mem_rwtyp`=010.
- **Enable rules:**
  - `mem_rden` and `mem_wren` are never high together.
  - Both are low in IDLE, LDATA and MERGE.
  - `mem_address` is stable for the whole transaction.

## Timing
- **Reset values:** state IDLE; `req_ready`=1; `rsp_valid`=0; `rsp_err`=0; `rsp_rdata`=0; `mem_rden`=0; `mem_wren`=0; `mem_address`=0; `mem_data`=0; `mem_rwtyp`=000.
- **Latency**, with acceptance edge E and `rsp_valid` high in the cycle after the edge listed:
  - Error: E.
  - Direct store: E+1.
  - Load: E+2.
  - RMW store: E+3.
- **Response pulse:** `rsp_valid` lasts exactly one cycle. `rsp_rdata` and `rsp_err` are held until the next response.
- **Back-to-back:** a new request may be accepted in the same cycle as `rsp_valid`, because the state is already IDLE.
- **Handshake:** `req_*` are sampled only at acceptance. Changes while `req_ready`=0 are ignored.
- **Reset mid-operation:** async return to IDLE with reset values; an unfinished write is not performed and no response is issued. A read-modify-write interrupted before WR leaves RAM unchanged.

## Test plan
- **Word round trip:** SW addr 0x10, wdata 0xDEADBEEF → `mem_wren` 1 cycle, `mem_address`=4, `mem_rwtyp`=010, `rsp_valid` at E+1. Then LW 0x10 → `rsp_rdata`=0xDEADBEEF at E+2.
- **Sub-word loads:** word 0x80FF7F01 at 0x20.
  - LB 0x21 → 0x0000007F.
  - LB 0x23 → 0xFFFFFF80.
  - LBU 0x23 → 0x00000080.
  - LH 0x22 → 0xFFFF80FF.
  - LHU 0x22 → 0x000080FF.
- **RMW stores:** word 0x11223344 at 0x30.
  - SB 0x31 wdata 0xAA → RD, MERGE, WR with `mem_data`=0x1122AA44, `rwtyp`=010, `rsp_valid` at E+3.
  - SH 0x32 wdata 0xBEEF → 0xBEEFAA44.
  - SB 0x30 wdata 0x55 → single WR with `rwtyp`=000, `rsp_valid` at E+1.
- **Errors:** LH 0x41, SW 0x42, load funct3 011, and addr 0x00040000 with ADDR_WIDTH=16 → each gives `rsp_err`=1, `rsp_rdata`=0 at E, with no `mem_rden`/`mem_wren` pulse.
- **Back-to-back:** hold `req_valid` high with a load then a store → second request accepted in the first request's `rsp_valid` cycle; `req_ready`=0 during RD/LDATA/MERGE/WR.
- **Reset mid-RMW:** deassert `rstn` during MERGE of SB 0x31 → all outputs return to reset values, no `mem_wren`; after release, LW 0x30 returns the pre-store word.
